// File: rtl/seg7_scan_driver_if.sv
// Bus between the logic that owns the displayed number and the seven-segment
// scan driver: load strobe plus data in, registered display pins out.
interface seg7_scan_driver_if #(
   parameter int DIGITS = 4
);
   logic                  load;
   logic [4*DIGITS-1:0]   value;
   logic [DIGITS-1:0]     dp_in;
   logic [DIGITS-1:0]     blank_in;
   logic [6:0]            seg;
   logic                  dp;
   logic [DIGITS-1:0]     an;
   logic                  frame_start;

   modport master (
      output load, value, dp_in, blank_in,
      input  seg, dp, an, frame_start
   );

   modport slave (
      input  load, value, dp_in, blank_in,
      output seg, dp, an, frame_start
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: one registered segment bus scanned
// over DIGITS enables, with a shadow/display buffer pair committed at frame start.
module seg7_scan_driver #(
   parameter int DIGITS         = 4,
   parameter int SCAN_DIV       = 50000,
   parameter bit LZ_BLANK       = 1'b0,
   parameter bit SEG_ACTIVE_LOW = 1'b0,
   parameter bit AN_ACTIVE_LOW  = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   seg7_scan_driver_if.slave  bus
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [CW-1:0]          r_cnt;
   logic [IW-1:0]          r_idx;
   logic                   r_pending;
   logic [4*DIGITS-1:0]    r_shValue, r_dsValue;
   logic [DIGITS-1:0]      r_shDp, r_dsDp, r_shBlank, r_dsBlank;
   logic [6:0]             r_seg;
   logic                   r_dp;
   logic [DIGITS-1:0]      r_an;
   logic                   r_frameStart;

   logic                   w_tick;
   logic [IW-1:0]          w_nidx;
   logic                   w_commit;
   logic [4*DIGITS-1:0]    w_effValue;
   logic [DIGITS-1:0]      w_effDp, w_effBlank, w_supp, w_dark, w_anNext;
   logic                   w_allZero;
   logic [3:0]             w_nib;

   function automatic logic [6:0] segCode(input logic [3:0] n);
      logic [6:0] c;
      case (n)
         4'h0: c = 7'b1111110;
         4'h1: c = 7'b1100000;
         4'h2: c = 7'b1011101;
         4'h3: c = 7'b1111001;
         4'h4: c = 7'b1100011;
         4'h5: c = 7'b0111011;
         4'h6: c = 7'b0111111;
         4'h7: c = 7'b1101000;
         4'h8: c = 7'b1111111;
         4'h9: c = 7'b1111011;
         4'hA: c = 7'b1101111;
         4'hB: c = 7'b0110111;
         4'hC: c = 7'b0011110;
         4'hD: c = 7'b1110101;
         4'hE: c = 7'b0011111;
         default: c = 7'b0001111;
      endcase
      return c;
   endfunction

   always_comb begin
      w_tick = (r_cnt == CNT_LAST);
      w_nidx = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_idx <= IDX_LAST;
      end else if (w_tick) begin
         r_cnt <= '0;
         r_idx <= w_nidx;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // A load on the commit edge still sees the old shadow go out; the new data
   // waits in the shadow with pending held for the following frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= 1'b0;
         r_shValue <= '0;
         r_shDp    <= '0;
         r_shBlank <= '0;
         r_dsValue <= '0;
         r_dsDp    <= '0;
         r_dsBlank <= '0;
      end else begin
         if (w_commit) begin
            r_dsValue <= r_shValue;
            r_dsDp    <= r_shDp;
            r_dsBlank <= r_shBlank;
         end
         if (bus.load) begin
            r_shValue <= bus.value;
            r_shDp    <= bus.dp_in;
            r_shBlank <= bus.blank_in;
            r_pending <= 1'b1;
         end else if (w_commit) begin
            r_pending <= 1'b0;
         end
      end
   end

   always_comb begin
      w_commit   = w_tick && (w_nidx == '0) && r_pending;
      w_effValue = w_commit ? r_shValue : r_dsValue;
      w_effDp    = w_commit ? r_shDp    : r_dsDp;
      w_effBlank = w_commit ? r_shBlank : r_dsBlank;
   end

   // Walk down from the top digit; digit 0 is never suppressed.
   always_comb begin
      w_supp    = '0;
      w_allZero = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         w_allZero = w_allZero & (w_effValue[4*i +: 4] == 4'h0);
         w_supp[i] = LZ_BLANK & w_allZero;
      end
   end

   always_comb begin
      w_dark           = w_effBlank | w_supp;
      w_nib            = w_effValue[{w_nidx, 2'b00} +: 4];
      w_anNext         = '0;
      w_anNext[w_nidx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg        <= '0;
         r_dp         <= 1'b0;
         r_an         <= '0;
         r_frameStart <= 1'b0;
      end else begin
         r_frameStart <= w_tick && (w_nidx == '0);
         if (w_tick) begin
            r_an  <= w_anNext;
            r_seg <= w_dark[w_nidx] ? 7'b0000000 : segCode(w_nib);
            r_dp  <= w_effDp[w_nidx] & ~w_dark[w_nidx];
         end
      end
   end

   // Polarity is a fixed XOR on the registered levels, so pins stay glitch-free.
   assign bus.seg         = r_seg ^ {7{SEG_ACTIVE_LOW}};
   assign bus.dp          = r_dp ^ SEG_ACTIVE_LOW;
   assign bus.an          = r_an ^ {DIGITS{AN_ACTIVE_LOW}};
   assign bus.frame_start = r_frameStart;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three parameter sets share one stimulus stream
// and are compared every cycle against a frame-level model, plus vector tables.
module tb_seg7_scan_driver;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        stLoad  = 1'b0;
   logic [15:0] stValue = '0;
   logic [3:0]  stDp    = '0;
   logic [3:0]  stBlank = '0;

   int nChecks = 0;
   int nFail   = 0;

   seg7_scan_driver_if #(.DIGITS(4)) ifA ();
   seg7_scan_driver_if #(.DIGITS(4)) ifB ();
   seg7_scan_driver_if #(.DIGITS(3)) ifC ();

   assign ifA.load = stLoad;  assign ifA.value = stValue;
   assign ifA.dp_in = stDp;   assign ifA.blank_in = stBlank;
   assign ifB.load = stLoad;  assign ifB.value = stValue;
   assign ifB.dp_in = stDp;   assign ifB.blank_in = stBlank;
   assign ifC.load = stLoad;  assign ifC.value = stValue[11:0];
   assign ifC.dp_in = stDp[2:0]; assign ifC.blank_in = stBlank[2:0];

   seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(3), .LZ_BLANK(1'b0),
                      .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0))
      dutA (.clk(clk), .rst_n(rst_n), .bus(ifA));
   seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(3), .LZ_BLANK(1'b1),
                      .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1))
      dutB (.clk(clk), .rst_n(rst_n), .bus(ifB));
   seg7_scan_driver #(.DIGITS(3), .SCAN_DIV(1), .LZ_BLANK(1'b0),
                      .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0))
      dutC (.clk(clk), .rst_n(rst_n), .bus(ifC));

   localparam int CFG_DIGITS [3] = '{4, 4, 3};
   localparam int CFG_DIV    [3] = '{3, 3, 1};
   localparam bit CFG_LZ     [3] = '{1'b0, 1'b1, 1'b0};
   localparam bit CFG_SL     [3] = '{1'b0, 1'b1, 1'b0};
   localparam bit CFG_AL     [3] = '{1'b0, 1'b1, 1'b0};

   localparam logic [6:0] SEGCODE [16] = '{
      7'b1111110, 7'b1100000, 7'b1011101, 7'b1111001,
      7'b1100011, 7'b0111011, 7'b0111111, 7'b1101000,
      7'b1111111, 7'b1111011, 7'b1101111, 7'b0110111,
      7'b0011110, 7'b1110101, 7'b0011111, 7'b0001111};

   // Frame-level model: the displayed frame is whatever was loaded last before
   // the frame-start edge; the lit digit follows from the edge count alone.
   int          mK      [3];
   int          mDigit  [3];
   bit          mShown  [3];
   bit          mFs     [3];
   logic [15:0] mLastVal [3], mFrameVal [3];
   logic [3:0]  mLastDp  [3], mFrameDp  [3];
   logic [3:0]  mLastBlk [3], mFrameBlk [3];

   function automatic logic [15:0] valMask(input int d);
      return 16'((32'h1 << (4 * d)) - 1);
   endfunction

   function automatic logic [3:0] digMask(input int d);
      return 4'((32'h1 << d) - 1);
   endfunction

   task automatic modelReset();
      for (int j = 0; j < 3; j++) begin
         mK[j] = 0; mDigit[j] = 0; mShown[j] = 1'b0; mFs[j] = 1'b0;
         mLastVal[j] = '0; mFrameVal[j] = '0;
         mLastDp[j]  = '0; mFrameDp[j]  = '0;
         mLastBlk[j] = '0; mFrameBlk[j] = '0;
      end
   endtask

   task automatic modelStep();
      for (int j = 0; j < 3; j++) begin
         mK[j]++;
         mFs[j] = 1'b0;
         if (mK[j] % CFG_DIV[j] == 0) begin
            mDigit[j] = (mK[j] / CFG_DIV[j] - 1) % CFG_DIGITS[j];
            mShown[j] = 1'b1;
            if (mDigit[j] == 0) begin
               mFrameVal[j] = mLastVal[j];
               mFrameDp[j]  = mLastDp[j];
               mFrameBlk[j] = mLastBlk[j];
               mFs[j]       = 1'b1;
            end
         end
         if (stLoad) begin
            mLastVal[j] = stValue & valMask(CFG_DIGITS[j]);
            mLastDp[j]  = stDp & digMask(CFG_DIGITS[j]);
            mLastBlk[j] = stBlank & digMask(CFG_DIGITS[j]);
         end
      end
   endtask

   task automatic modelExpect(input int j, output logic [6:0] es, output logic ed,
                              output logic [3:0] ea, output logic ef);
      int d;
      logic dark;
      es = '0; ed = 1'b0; ea = '0;
      if (mShown[j]) begin
         d    = mDigit[j];
         dark = mFrameBlk[j][d] ||
                (CFG_LZ[j] && d > 0 && (mFrameVal[j] >> (4 * d)) == 16'h0);
         es   = dark ? 7'b0 : SEGCODE[4'(mFrameVal[j] >> (4 * d))];
         ed   = mFrameDp[j][d] && !dark;
         ea   = 4'(32'h1 << d);
      end
      if (CFG_SL[j]) begin es = ~es; ed = ~ed; end
      if (CFG_AL[j]) ea = ea ^ digMask(CFG_DIGITS[j]);
      ef = mFs[j];
   endtask

   task automatic checkOutput(input string name, input int j, input logic [6:0] es,
                              input logic ed, input logic [3:0] ea, input logic ef);
      logic [6:0] as;
      logic       ad, af;
      logic [3:0] aa;
      case (j)
         0:       begin as = ifA.seg; ad = ifA.dp; aa = ifA.an; af = ifA.frame_start; end
         1:       begin as = ifB.seg; ad = ifB.dp; aa = ifB.an; af = ifB.frame_start; end
         default: begin as = ifC.seg; ad = ifC.dp; aa = {1'b0, ifC.an}; af = ifC.frame_start; end
      endcase
      nChecks++;
      if (as !== es || ad !== ed || aa !== ea || af !== ef) begin
         nFail++;
         $display("[TB] FAIL %s inst=%0d t=%0t seg=%b want %b dp=%b want %b an=%b want %b fs=%b want %b",
                  name, j, $time, as, es, ad, ed, aa, ea, af, ef);
      end
   endtask

   task automatic modelCheckAll(input string name);
      logic [6:0] es;
      logic       ed, ef;
      logic [3:0] ea;
      for (int j = 0; j < 3; j++) begin
         modelExpect(j, es, ed, ea, ef);
         checkOutput(name, j, es, ed, ea, ef);
      end
   endtask

   task automatic applyStimulus(input logic ld, input logic [15:0] val,
                                input logic [3:0] dpi, input logic [3:0] blk);
      stLoad = ld; stValue = val; stDp = dpi; stBlank = blk;
      @(posedge clk);
      if (rst_n) modelStep();
      #1;
      stLoad = 1'b0;
      modelCheckAll("model");
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #1;
      modelReset();
      modelCheckAll("reset");
      checkOutput("resetA", 0, 7'b0000000, 1'b0, 4'b0000, 1'b0);
      checkOutput("resetB", 1, 7'b1111111, 1'b1, 4'b1111, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit          rst;
      int          inst;
      int          skip;
      bit          load;
      logic [15:0] value;
      logic [3:0]  dpIn;
      logic [3:0]  blankIn;
      logic [6:0]  expSeg;
      logic        expDp;
      logic [3:0]  expAn;
      logic        expFs;
   } vec_t;

   vec_t vecs[$];

   initial begin
      vec_t v;
      bit   found;

      // Instance A after reset: scan order, mid-frame load, commit-edge load, blanking.
      vecs.push_back('{1, 0, 0, 0, 16'h0000, 4'h0, 4'h0, 7'b0000000, 0, 4'b0000, 0});
      vecs.push_back('{0, 0, 0, 0, 16'h0000, 4'h0, 4'h0, 7'b0000000, 0, 4'b0000, 0});
      vecs.push_back('{0, 0, 0, 0, 16'h0000, 4'h0, 4'h0, 7'b1111110, 0, 4'b0001, 1});
      vecs.push_back('{0, 0, 0, 0, 16'h0000, 4'h0, 4'h0, 7'b1111110, 0, 4'b0001, 0});
      vecs.push_back('{0, 0, 1, 0, 16'h0000, 4'h0, 4'h0, 7'b1111110, 0, 4'b0010, 0});
      vecs.push_back('{0, 0, 0, 1, 16'h0A5F, 4'h4, 4'h0, 7'b1111110, 0, 4'b0010, 0});
      vecs.push_back('{0, 0, 1, 0, 16'h0000, 4'h0, 4'h0, 7'b1111110, 0, 4'b0100, 0});
      vecs.push_back('{0, 0, 2, 0, 16'h0000, 4'h0, 4'h0, 7'b1111110, 0, 4'b1000, 0});
      vecs.push_back('{0, 0, 2, 0, 16'h0000, 4'h0, 4'h0, 7'b0001111, 0, 4'b0001, 1});
      vecs.push_back('{0, 0, 2, 0, 16'h0000, 4'h0, 4'h0, 7'b0111011, 0, 4'b0010, 0});
      vecs.push_back('{0, 0, 2, 0, 16'h0000, 4'h0, 4'h0, 7'b1101111, 1, 4'b0100, 0});
      vecs.push_back('{0, 0, 0, 1, 16'h1234, 4'h0, 4'h0, 7'b1101111, 1, 4'b0100, 0});
      vecs.push_back('{0, 0, 1, 0, 16'h0000, 4'h0, 4'h0, 7'b1111110, 0, 4'b1000, 0});
      vecs.push_back('{0, 0, 2, 1, 16'h5678, 4'h0, 4'h0, 7'b1100011, 0, 4'b0001, 1});
      vecs.push_back('{0, 0, 2, 0, 16'h0000, 4'h0, 4'h0, 7'b1111001, 0, 4'b0010, 0});
      vecs.push_back('{0, 0, 8, 0, 16'h0000, 4'h0, 4'h0, 7'b1111111, 0, 4'b0001, 1});
      vecs.push_back('{0, 0, 2, 0, 16'h0000, 4'h0, 4'h0, 7'b1101000, 0, 4'b0010, 0});
      vecs.push_back('{0, 0, 0, 1, 16'h5678, 4'h0, 4'h2, 7'b1101000, 0, 4'b0010, 0});
      vecs.push_back('{0, 0, 7, 0, 16'h0000, 4'h0, 4'h0, 7'b1111111, 0, 4'b0001, 1});
      vecs.push_back('{0, 0, 2, 0, 16'h0000, 4'h0, 4'h0, 7'b0000000, 0, 4'b0010, 0});
      // Instance B (leading-zero blanking, inverted pins).
      vecs.push_back('{1, 1, 0, 1, 16'h0007, 4'h0, 4'h0, 7'b1111111, 1, 4'b1111, 0});
      vecs.push_back('{0, 1, 1, 0, 16'h0000, 4'h0, 4'h0, 7'b0010111, 1, 4'b1110, 1});
      vecs.push_back('{0, 1, 2, 0, 16'h0000, 4'h0, 4'h0, 7'b1111111, 1, 4'b1101, 0});
      vecs.push_back('{0, 1, 2, 0, 16'h0000, 4'h0, 4'h0, 7'b1111111, 1, 4'b1011, 0});
      vecs.push_back('{0, 1, 2, 0, 16'h0000, 4'h0, 4'h0, 7'b1111111, 1, 4'b0111, 0});
      vecs.push_back('{0, 1, 0, 1, 16'h0000, 4'h0, 4'h0, 7'b1111111, 1, 4'b0111, 0});
      vecs.push_back('{0, 1, 1, 0, 16'h0000, 4'h0, 4'h0, 7'b0000001, 1, 4'b1110, 1});
      vecs.push_back('{0, 1, 2, 0, 16'h0000, 4'h0, 4'h0, 7'b1111111, 1, 4'b1101, 0});
      vecs.push_back('{0, 1, 0, 1, 16'h0001, 4'h0, 4'h0, 7'b1111111, 1, 4'b1101, 0});
      vecs.push_back('{0, 1, 7, 0, 16'h0000, 4'h0, 4'h0, 7'b0011111, 1, 4'b1110, 1});

      #2;
      foreach (vecs[k]) begin
         v = vecs[k];
         if (v.rst) doReset();
         for (int s = 0; s < v.skip; s++) applyStimulus(1'b0, 16'h0000, 4'h0, 4'h0);
         applyStimulus(v.load, v.value, v.dpIn, v.blankIn);
         checkOutput($sformatf("vec%0d", k), v.inst, v.expSeg, v.expDp, v.expAn, v.expFs);
      end

      $display("[TB] random phase");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom % 6) == 0, 16'($urandom), 4'($urandom),
                       4'($urandom & $urandom & $urandom));
      end

      // Reset while digit 2 of A is lit and a load is still pending.
      found = 1'b0;
      for (int i = 0; i < 24 && !found; i++) begin
         if (mShown[0] && mDigit[0] == 2) found = 1'b1;
         else applyStimulus(1'b0, 16'h0000, 4'h0, 4'h0);
      end
      if (!found) begin
         nChecks++;
         nFail++;
         $display("[TB] FAIL midReset digit 2 never reached, got digit %0d want 2", mDigit[0]);
      end
      applyStimulus(1'b1, 16'h9999, 4'hF, 4'h0);
      doReset();
      applyStimulus(1'b0, 16'h0000, 4'h0, 4'h0);
      applyStimulus(1'b0, 16'h0000, 4'h0, 4'h0);
      checkOutput("restartIdle", 0, 7'b0000000, 1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b0, 16'h0000, 4'h0, 4'h0);
      checkOutput("restartA", 0, 7'b1111110, 1'b0, 4'b0001, 1'b1);
      checkOutput("restartB", 1, 7'b0000001, 1'b1, 4'b1110, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired, got no end of test want finish by 1000000");
      $fatal(1, "[TB] watchdog");
   end

endmodule
